// File: rtl/ahb3lite_arbiter.sv
// rtl/ahb3lite_arbiter.sv - round-robin AHB-Lite address-phase arbiter with burst locking
//
// Shares one AHB-Lite slave port between N_MASTERS requesters. The address phase is
// granted to one requester at a time; fixed-length and INCR bursts hold the grant until
// they finish (INCR is capped at MAX_INCR_BEATS beats). HMASTER_DATA trails HMASTER by
// one accepted transfer so the external data muxes follow the data-phase owner.
//
// Configuration macro: AHB_ARB_FIXED_PRIO_EN
//   undefined (default) : round-robin starting after the last winner
//   defined             : fixed priority, lowest set req index wins
//
// Ports:
//   HCLK          in   clock, all state on posedge
//   HRESETn       in   synchronous active-low reset
//   req           in   per-master request level [N_MASTERS]
//   HTRANS        in   transfer type of current owner (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST        in   burst type of current owner
//   HREADY        in   slave HREADYOUT
//   HGRANT        out  one-hot address-phase grant, zero = no owner
//   HMASTER       out  address-phase owner index
//   HMASTER_DATA  out  data-phase owner index
//   bus_busy      out  high while a burst holds the bus
module ahb3lite_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int MAX_INCR_BEATS = 16,
  localparam int MW            = $clog2(N_MASTERS)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [N_MASTERS-1:0] req,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HBURST,
  input  logic                 HREADY,
  output logic [N_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]        HMASTER,
  output logic [MW-1:0]        HMASTER_DATA,
  output logic                 bus_busy
);

  // Beat counter must hold the longest remaining count (15 or MAX_INCR_BEATS-1).
  localparam int CW = $clog2((MAX_INCR_BEATS > 16) ? MAX_INCR_BEATS : 16);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;
  localparam logic [2:0] BU_WRAP4  = 3'd2;
  localparam logic [2:0] BU_INCR4  = 3'd3;
  localparam logic [2:0] BU_WRAP8  = 3'd4;
  localparam logic [2:0] BU_INCR8  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [N_MASTERS-1:0]   grant_q;
  logic [MW-1:0]          master_q;
  logic [MW-1:0]          master_data_q;
  logic [MW-1:0]          last_winner_q;

  logic                   ap;
  logic                   found;
  logic [MW-1:0]          winner;
  logic [CW-1:0]          burst_len_m1;

  // Remaining beats after the NONSEQ of a fixed-length burst.
  always_comb begin
    burst_len_m1 = CW'(15);
    case (HBURST)
      BU_WRAP4, BU_INCR4: burst_len_m1 = CW'(3);
      BU_WRAP8, BU_INCR8: burst_len_m1 = CW'(7);
      default:            burst_len_m1 = CW'(15);
    endcase
  end

  // Winner selection. In round-robin mode the scan starts just after the last winner,
  // so the current owner is naturally the last candidate considered.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
`ifdef AHB_ARB_FIXED_PRIO_EN
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        found  = 1'b1;
        winner = MW'(i);
      end
    end
`else
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = int'(last_winner_q) + i;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!found && req[MW'(idx)]) begin
        found  = 1'b1;
        winner = MW'(idx);
      end
    end
`endif
  end

  // Next-state logic; nothing advances while HREADY is low.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ap      = 1'b0;
    if (HREADY) begin
      case (state_q)
        ST_IDLE: ap = 1'b1;
        ST_OWNED: begin
          if (HTRANS == TR_IDLE) begin
            ap = 1'b1;
          end else if (HTRANS == TR_NONSEQ) begin
            if (HBURST == BU_SINGLE) begin
              ap = 1'b1;
            end else if (HBURST == BU_INCR) begin
              if (MAX_INCR_BEATS == 1) begin
                ap = 1'b1;
              end else begin
                state_d = ST_LOCKED;
                count_d = CW'(MAX_INCR_BEATS - 1);
              end
            end else begin
              state_d = ST_LOCKED;
              count_d = burst_len_m1;
            end
          end
        end
        ST_LOCKED: begin
          case (HTRANS)
            TR_SEQ: begin
              if (count_q <= CW'(1)) ap = 1'b1;
              else                   count_d = count_q - CW'(1);
            end
            TR_BUSY: count_d = count_q;
            // IDLE/NONSEQ ends an INCR burst; on a fixed burst it is an early
            // termination and is treated the same way.
            default: ap = 1'b1;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
      if (ap) begin
        state_d = found ? ST_OWNED : ST_IDLE;
        count_d = '0;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      grant_q       <= '0;
      master_q      <= '0;
      master_data_q <= '0;
      last_winner_q <= MW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (HREADY) master_data_q <= master_q;
      if (ap) begin
        if (found) begin
          grant_q       <= {{(N_MASTERS-1){1'b0}}, 1'b1} << winner;
          master_q      <= winner;
          last_winner_q <= winner;
        end else begin
          grant_q <= '0;
        end
      end
    end
  end

  // Output logic.
  always_comb begin
    HGRANT       = grant_q;
    HMASTER      = master_q;
    HMASTER_DATA = master_data_q;
    bus_busy     = (state_q == ST_LOCKED);
  end

endmodule

// File: tb/tb_ahb3lite_arbiter.sv
// tb/tb_ahb3lite_arbiter.sv - directed self-checking bench for ahb3lite_arbiter
module tb_ahb3lite_arbiter;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_INCR8 = 3'd5;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] req;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;

  logic [3:0] HGRANT, HGRANT_4;
  logic [1:0] HMASTER, HMASTER_4;
  logic [1:0] HMASTER_DATA, HMASTER_DATA_4;
  logic       bus_busy, bus_busy_4;

  int checks = 0;
  int failures = 0;

  logic [1:0] tr_v [12];
  logic       rdy_v[12];
  logic [3:0] gnt_v[12];
  logic       bsy_v[12];
  logic [1:0] mst_v[5];
  logic [1:0] dat_v[5];

  always #5 HCLK = ~HCLK;

  ahb3lite_arbiter #(.N_MASTERS(4), .MAX_INCR_BEATS(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .HTRANS(HTRANS), .HBURST(HBURST),
    .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTER_DATA(HMASTER_DATA),
    .bus_busy(bus_busy)
  );

  ahb3lite_arbiter #(.N_MASTERS(4), .MAX_INCR_BEATS(4)) dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .HTRANS(HTRANS), .HBURST(HBURST),
    .HREADY(HREADY), .HGRANT(HGRANT_4), .HMASTER(HMASTER_4), .HMASTER_DATA(HMASTER_DATA_4),
    .bus_busy(bus_busy_4)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    req     = 4'b0000;
    HTRANS  = T_IDLE;
    HBURST  = B_SINGLE;
    HREADY  = 1'b1;
    tick();
    tick();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (HGRANT !== 4'b0000) begin failures++; $display("FAIL reset_hgrant: got %b expected %b", HGRANT, 4'b0000); end
    checks++; if (HMASTER !== 2'd0) begin failures++; $display("FAIL reset_hmaster: got %0d expected %0d", HMASTER, 0); end
    checks++; if (HMASTER_DATA !== 2'd0) begin failures++; $display("FAIL reset_hmaster_data: got %0d expected %0d", HMASTER_DATA, 0); end
    checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL reset_bus_busy: got %b expected %b", bus_busy, 1'b0); end
  endtask

  task automatic test_first_grant();
    do_reset();
    req = 4'b0101;
    tick();
    checks++; if (HGRANT !== 4'b0001) begin failures++; $display("FAIL first_grant_hgrant: got %b expected %b", HGRANT, 4'b0001); end
    checks++; if (HMASTER !== 2'd0) begin failures++; $display("FAIL first_grant_hmaster: got %0d expected %0d", HMASTER, 0); end
    req = 4'b0001;
    tick();
    checks++; if (HMASTER_DATA !== 2'd0) begin failures++; $display("FAIL first_grant_data: got %0d expected %0d", HMASTER_DATA, 0); end
    checks++; if (HGRANT !== 4'b0001) begin failures++; $display("FAIL first_grant_sole: got %b expected %b", HGRANT, 4'b0001); end
  endtask

  task automatic test_hready_low_and_no_req();
    do_reset();
    req    = 4'b0100;
    HREADY = 1'b0;
    tick();
    checks++; if (HGRANT !== 4'b0000) begin failures++; $display("FAIL stall_no_grant: got %b expected %b", HGRANT, 4'b0000); end
    HREADY = 1'b1;
    tick();
    checks++; if (HGRANT !== 4'b0100) begin failures++; $display("FAIL stall_then_grant: got %b expected %b", HGRANT, 4'b0100); end
    checks++; if (HMASTER !== 2'd2) begin failures++; $display("FAIL stall_then_master: got %0d expected %0d", HMASTER, 2); end
    req = 4'b0000;
    tick();
    checks++; if (HGRANT !== 4'b0000) begin failures++; $display("FAIL no_req_grant: got %b expected %b", HGRANT, 4'b0000); end
    checks++; if (HMASTER !== 2'd2) begin failures++; $display("FAIL no_req_master_hold: got %0d expected %0d", HMASTER, 2); end
  endtask

  task automatic test_round_robin();
    do_reset();
    mst_v = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    dat_v = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    req    = 4'b1111;
    HTRANS = T_NONSEQ;
    HBURST = B_SINGLE;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (HMASTER !== mst_v[k]) begin failures++; $display("FAIL rr_hmaster[%0d]: got %0d expected %0d", k, HMASTER, mst_v[k]); end
      checks++; if (HGRANT !== (4'b0001 << mst_v[k])) begin failures++; $display("FAIL rr_hgrant[%0d]: got %b expected %b", k, HGRANT, 4'b0001 << mst_v[k]); end
      checks++; if (HMASTER_DATA !== dat_v[k]) begin failures++; $display("FAIL rr_hmaster_data[%0d]: got %0d expected %0d", k, HMASTER_DATA, dat_v[k]); end
    end
  endtask

  task automatic test_incr4_lock();
    do_reset();
    req = 4'b0110;
    tick();
    checks++; if (HGRANT !== 4'b0010) begin failures++; $display("FAIL incr4_grant: got %b expected %b", HGRANT, 4'b0010); end
    checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL incr4_busy_beat1: got %b expected %b", bus_busy, 1'b0); end
    HTRANS = T_NONSEQ;
    HBURST = B_INCR4;
    for (int b = 2; b <= 4; b++) begin
      tick();
      HTRANS = T_SEQ;
      if (b == 3) req = 4'b0100;
      checks++; if (HGRANT !== 4'b0010) begin failures++; $display("FAIL incr4_hold[beat%0d]: got %b expected %b", b, HGRANT, 4'b0010); end
      checks++; if (bus_busy !== 1'b1) begin failures++; $display("FAIL incr4_busy[beat%0d]: got %b expected %b", b, bus_busy, 1'b1); end
    end
    tick();
    checks++; if (HGRANT !== 4'b0100) begin failures++; $display("FAIL incr4_handover: got %b expected %b", HGRANT, 4'b0100); end
    checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL incr4_busy_end: got %b expected %b", bus_busy, 1'b0); end
  endtask

  task automatic test_incr8_stall();
    do_reset();
    tr_v  = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_BUSY, T_SEQ, T_SEQ, T_SEQ, T_SEQ};
    rdy_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    gnt_v = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
              4'b0001, 4'b0001, 4'b0001, 4'b0010};
    bsy_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    req = 4'b0011;
    tick();
    checks++; if (HGRANT !== 4'b0001) begin failures++; $display("FAIL incr8_grant: got %b expected %b", HGRANT, 4'b0001); end
    HBURST = B_INCR8;
    for (int s = 0; s < 12; s++) begin
      HTRANS = tr_v[s];
      HREADY = rdy_v[s];
      tick();
      checks++; if (HGRANT !== gnt_v[s]) begin failures++; $display("FAIL incr8_hgrant[step%0d]: got %b expected %b", s, HGRANT, gnt_v[s]); end
      checks++; if (bus_busy !== bsy_v[s]) begin failures++; $display("FAIL incr8_busy[step%0d]: got %b expected %b", s, bus_busy, bsy_v[s]); end
    end
    checks++; if (HMASTER !== 2'd1) begin failures++; $display("FAIL incr8_next_master: got %0d expected %0d", HMASTER, 1); end
    HREADY = 1'b1;
  endtask

  task automatic test_max_incr_and_reset();
    do_reset();
    req = 4'b1000;
    tick();
    checks++; if (HGRANT_4 !== 4'b1000) begin failures++; $display("FAIL maxincr_grant3: got %b expected %b", HGRANT_4, 4'b1000); end
    req    = 4'b1001;
    HTRANS = T_NONSEQ;
    HBURST = B_INCR;
    for (int b = 2; b <= 4; b++) begin
      tick();
      HTRANS = T_SEQ;
      checks++; if (HGRANT_4 !== 4'b1000) begin failures++; $display("FAIL maxincr_hold[beat%0d]: got %b expected %b", b, HGRANT_4, 4'b1000); end
    end
    tick();
    checks++; if (HGRANT_4 !== 4'b0001) begin failures++; $display("FAIL maxincr_handover: got %b expected %b", HGRANT_4, 4'b0001); end
    checks++; if (HMASTER_4 !== 2'd0) begin failures++; $display("FAIL maxincr_master: got %0d expected %0d", HMASTER_4, 0); end
    checks++; if (HGRANT !== 4'b1000) begin failures++; $display("FAIL maxincr16_still_locked: got %b expected %b", HGRANT, 4'b1000); end
    HTRANS = T_NONSEQ;
    tick();
    HTRANS = T_SEQ;
    tick();
    checks++; if (bus_busy_4 !== 1'b1) begin failures++; $display("FAIL midburst_busy: got %b expected %b", bus_busy_4, 1'b1); end
    HRESETn = 1'b0;
    tick();
    checks++; if (HGRANT_4 !== 4'b0000) begin failures++; $display("FAIL midburst_reset_grant: got %b expected %b", HGRANT_4, 4'b0000); end
    checks++; if (bus_busy_4 !== 1'b0) begin failures++; $display("FAIL midburst_reset_busy: got %b expected %b", bus_busy_4, 1'b0); end
    checks++; if (HMASTER_4 !== 2'd0) begin failures++; $display("FAIL midburst_reset_master: got %0d expected %0d", HMASTER_4, 0); end
    HRESETn = 1'b1;
  endtask

  task automatic test_priority_1110();
    do_reset();
`ifdef AHB_ARB_FIXED_PRIO_EN
    mst_v = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`else
    mst_v = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
`endif
    req    = 4'b1110;
    HTRANS = T_NONSEQ;
    HBURST = B_SINGLE;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (HMASTER !== mst_v[k]) begin failures++; $display("FAIL prio_hmaster[%0d]: got %0d expected %0d", k, HMASTER, mst_v[k]); end
      checks++; if (HGRANT !== (4'b0001 << mst_v[k])) begin failures++; $display("FAIL prio_hgrant[%0d]: got %b expected %b", k, HGRANT, 4'b0001 << mst_v[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_hready_low_and_no_req();
    test_round_robin();
    test_incr4_lock();
    test_incr8_stall();
    test_max_incr_and_reset();
    test_priority_1110();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
